// File: rtl/branch_resolve_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_arbiter_pkg / branch_resolve_arbiter_if
// Brief    : Shared branch types and the FU <-> arbiter bundle. The
//            BR_ARB_PERF_EN macro adds the performance-counter signals.
// Revision : 1.0 - initial release
// ============================================================================
package branch_resolve_arbiter_pkg;
    localparam int c_BR_MASK_W = 4;
    localparam int c_ADDR_W    = 32;

    typedef logic [c_BR_MASK_W-1:0] BR_MASK;
    typedef logic [c_ADDR_W-1:0]    ADDR;

    typedef enum logic [1:0] {
        NOTHING = 2'd0,
        CLEAR   = 2'd1,
        SQUASH  = 2'd2
    } BR_TASK;

    typedef struct packed {
        BR_MASK b_id;
        BR_MASK b_mask;
    } DECODED_VALS;

    typedef struct packed {
        DECODED_VALS decoded_vals;
        ADDR         result;
    } FU_PACKET;
endpackage

interface branch_resolve_arbiter_if
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int NUM_BR_FU = 2
) ();
    logic     [NUM_BR_FU-1:0] fu_data_ready;
    FU_PACKET [NUM_BR_FU-1:0] fu_pack;
    BR_TASK   [NUM_BR_FU-1:0] fu_br_task;
    BR_TASK                   rem_br_task;
    BR_MASK                   rem_b_id;
    ADDR                      rem_target;
    logic                     accept_ready;
`ifdef BR_ARB_PERF_EN
    logic [31:0]              perf_clear_cnt;
    logic [31:0]              perf_squash_cnt;
    logic [31:0]              perf_flush_cnt;

    modport master (
        output fu_data_ready, fu_pack, fu_br_task,
        input  rem_br_task, rem_b_id, rem_target, accept_ready,
        input  perf_clear_cnt, perf_squash_cnt, perf_flush_cnt
    );
    modport slave (
        input  fu_data_ready, fu_pack, fu_br_task,
        output rem_br_task, rem_b_id, rem_target, accept_ready,
        output perf_clear_cnt, perf_squash_cnt, perf_flush_cnt
    );
`else
    modport master (
        output fu_data_ready, fu_pack, fu_br_task,
        input  rem_br_task, rem_b_id, rem_target, accept_ready
    );
    modport slave (
        input  fu_data_ready, fu_pack, fu_br_task,
        output rem_br_task, rem_b_id, rem_target, accept_ready
    );
`endif
endinterface
`default_nettype wire

// File: rtl/branch_resolve_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_arbiter
// Brief    : Buffers FU branch resolutions and broadcasts the oldest one per
//            cycle; optional counters under BR_ARB_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_arbiter
    import branch_resolve_arbiter_pkg::*;
#(
    parameter int NUM_BR_FU = 2,
    parameter int DEPTH     = 4
) (
    input  wire logic               clock,
    input  wire logic               reset,
    branch_resolve_arbiter_if.slave bus
);
    localparam int c_LANE_W = (NUM_BR_FU > 1) ? $clog2(NUM_BR_FU) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] r_valid;
    BR_MASK           r_bid    [DEPTH];
    BR_MASK           r_bmask  [DEPTH];
    BR_TASK           r_task   [DEPTH];
    ADDR              r_target [DEPTH];

    BR_TASK r_rem_task;
    BR_MASK r_rem_bid;
    ADDR    r_rem_target;
    logic   r_accept_ready;

    BR_MASK           w_others [DEPTH];
    logic [DEPTH-1:0] w_elig;
    logic [DEPTH-1:0] w_sel_oh;
    logic             w_sel_vld;
    BR_MASK           w_sel_bid;
    BR_TASK           w_sel_task;
    ADDR              w_sel_target;
    BR_MASK           w_sel_sq_bid;
    BR_MASK           w_sel_clr_bid;

    // An entry is oldest when none of the other pending branches is in its mask.
    always_comb begin
        w_elig   = '0;
        w_sel_oh = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_others[i] = '0;
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && r_valid[j]) begin
                    w_others[i] = w_others[i] | r_bid[j];
                end
            end
            w_elig[i] = r_valid[i] && ((r_bmask[i] & w_others[i]) == '0);
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel_oh    = '0;
                w_sel_oh[i] = 1'b1;
            end
        end
        w_sel_vld    = |w_sel_oh;
        w_sel_bid    = '0;
        w_sel_task   = NOTHING;
        w_sel_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_bid    = r_bid[i];
                w_sel_task   = r_task[i];
                w_sel_target = r_target[i];
            end
        end
        w_sel_sq_bid  = (w_sel_task == SQUASH) ? w_sel_bid : '0;
        w_sel_clr_bid = (w_sel_task == CLEAR)  ? w_sel_bid : '0;
    end

    BR_MASK                w_rem_sq_bid;
    BR_MASK                w_rem_clr_bid;
    BR_MASK                w_lane_mask [NUM_BR_FU];
    logic [NUM_BR_FU-1:0]  w_lane_acc;
    logic [NUM_BR_FU-1:0]  w_lane_keep;

    always_comb begin
        w_rem_sq_bid  = (r_rem_task == SQUASH) ? r_rem_bid : '0;
        w_rem_clr_bid = (r_rem_task == CLEAR)  ? r_rem_bid : '0;
        for (int l = 0; l < NUM_BR_FU; l++) begin
            w_lane_mask[l] = bus.fu_pack[l].decoded_vals.b_mask & ~w_rem_clr_bid & ~w_sel_clr_bid;
            w_lane_acc[l]  = bus.fu_data_ready[l] && r_accept_ready;
            w_lane_keep[l] = w_lane_acc[l]
                          && ((bus.fu_pack[l].decoded_vals.b_mask & w_rem_sq_bid) == '0)
                          && ((bus.fu_pack[l].decoded_vals.b_mask & w_sel_sq_bid) == '0);
        end
    end

    logic [DEPTH-1:0]     w_free_scan;
    logic [DEPTH-1:0]     w_wr_en;
    logic [c_LANE_W-1:0]  w_wr_lane [DEPTH];
    logic [NUM_BR_FU-1:0] w_lane_done;

    // Lowest surviving lane takes the lowest free slot, then the next, and so on.
    always_comb begin
        w_free_scan = ~r_valid;
        w_wr_en     = '0;
        w_lane_done = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_wr_lane[i] = '0;
        end
        for (int l = 0; l < NUM_BR_FU; l++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_lane_keep[l] && !w_lane_done[l] && w_free_scan[i]) begin
                    w_wr_en[i]     = 1'b1;
                    w_wr_lane[i]   = c_LANE_W'(l);
                    w_free_scan[i] = 1'b0;
                    w_lane_done[l] = 1'b1;
                end
            end
        end
    end

    logic [DEPTH-1:0]   w_nxt_valid;
    logic [DEPTH-1:0]   w_flushed;
    logic [c_CNT_W-1:0] w_free_cnt;
    logic               w_nxt_ready;

    always_comb begin
        w_free_cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_flushed[i]   = r_valid[i] && !w_sel_oh[i] && ((r_bmask[i] & w_sel_sq_bid) != '0);
            w_nxt_valid[i] = (r_valid[i] && !w_sel_oh[i] && !w_flushed[i]) || w_wr_en[i];
            w_free_cnt     = w_free_cnt + c_CNT_W'(!w_nxt_valid[i]);
        end
        w_nxt_ready = (w_free_cnt >= c_CNT_W'(NUM_BR_FU));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid        <= '0;
            r_rem_task     <= NOTHING;
            r_rem_bid      <= '0;
            r_rem_target   <= '0;
            r_accept_ready <= 1'b1;
        end else begin
            r_valid        <= w_nxt_valid;
            r_rem_task     <= w_sel_task;
            r_rem_bid      <= w_sel_bid;
            r_rem_target   <= (w_sel_task == SQUASH) ? w_sel_target : '0;
            r_accept_ready <= w_nxt_ready;
        end
    end

    // Payload needs no reset: it is only ever observed behind r_valid.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (w_wr_en[i]) begin
                r_bid[i]    <= bus.fu_pack[w_wr_lane[i]].decoded_vals.b_id;
                r_bmask[i]  <= w_lane_mask[w_wr_lane[i]];
                r_task[i]   <= bus.fu_br_task[w_wr_lane[i]];
                r_target[i] <= bus.fu_pack[w_wr_lane[i]].result;
            end else begin
                r_bmask[i]  <= r_bmask[i] & ~w_sel_clr_bid;
            end
        end
    end

    assign bus.rem_br_task  = r_rem_task;
    assign bus.rem_b_id     = r_rem_bid;
    assign bus.rem_target   = r_rem_target;
    assign bus.accept_ready = r_accept_ready;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (r_accept_ready || (bus.fu_data_ready == '0))
                else $error("branch_resolve_arbiter: input while accept_ready low was dropped");
        end
    end
`endif

`ifdef BR_ARB_PERF_EN
    localparam int c_FL_W = $clog2(DEPTH + NUM_BR_FU + 1);

    logic [31:0]       r_perf_clear_cnt;
    logic [31:0]       r_perf_squash_cnt;
    logic [31:0]       r_perf_flush_cnt;
    logic [c_FL_W-1:0] w_flush_inc;
    logic [32:0]       w_flush_sum;

    always_comb begin
        w_flush_inc = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_flush_inc = w_flush_inc + c_FL_W'(w_flushed[i]);
        end
        for (int l = 0; l < NUM_BR_FU; l++) begin
            w_flush_inc = w_flush_inc + c_FL_W'(w_lane_acc[l] && !w_lane_keep[l]);
        end
        w_flush_sum = {1'b0, r_perf_flush_cnt} + 33'(w_flush_inc);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_perf_clear_cnt  <= '0;
            r_perf_squash_cnt <= '0;
            r_perf_flush_cnt  <= '0;
        end else begin
            if (w_sel_task == CLEAR && r_perf_clear_cnt != '1) begin
                r_perf_clear_cnt <= r_perf_clear_cnt + 32'd1;
            end
            if (w_sel_task == SQUASH && r_perf_squash_cnt != '1) begin
                r_perf_squash_cnt <= r_perf_squash_cnt + 32'd1;
            end
            r_perf_flush_cnt <= w_flush_sum[32] ? '1 : w_flush_sum[31:0];
        end
    end

    assign bus.perf_clear_cnt  = r_perf_clear_cnt;
    assign bus.perf_squash_cnt = r_perf_squash_cnt;
    assign bus.perf_flush_cnt  = r_perf_flush_cnt;
`endif
endmodule
`default_nettype wire
